// File: rtl/m_board_keeper_pkg.sv
// Shared board geometry, result codes and helpers for the Connect-Four board keeper.
// The board macros are the common header values used by the search side as well.
`ifndef M_BOARD_KEEPER_CONFIG
`define M_BOARD_KEEPER_CONFIG
`define FIELD_SIZE 42
`define COL_SIZE 3
`define PILED_COUNT_ARRAY_SIZE 21
`define N_ROWS 6
`define N_COLS 7
`define RES_OK 2'd0
`define RES_WIN 2'd1
`define RES_DRAW 2'd2
`define RES_ILLEGAL 2'd3
`endif

package m_board_keeper_pkg;
  localparam int N_ROWS  = `N_ROWS;
  localparam int N_COLS  = `N_COLS;
  localparam int FIELD_W = `FIELD_SIZE;
  localparam int PILED_W = `PILED_COUNT_ARRAY_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_PLACE, S_CHK} state_t;

  typedef logic [N_COLS-1:0][2:0] pile_t;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } dir_t;

  function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return 6'(N_COLS * int'(r) + int'(c));
  endfunction

  // Direction order: horizontal, vertical, rising diagonal, falling diagonal.
  function automatic dir_t dir_of(input logic [1:0] d);
    dir_t v;
    case (d)
      2'd0:    v = '{dr: 2'sd0, dc: 2'sd1};
      2'd1:    v = '{dr: 2'sd1, dc: 2'sd0};
      2'd2:    v = '{dr: 2'sd1, dc: 2'sd1};
      default: v = '{dr: 2'sd1, dc: -2'sd1};
    endcase
    return v;
  endfunction
endpackage

// File: rtl/m_board_keeper_run_counter.sv
// Combinational run length through (row,col) along +/-(dr,dc) on one side's bitboard.
// Walks are bounded by WIN_LEN-1 steps and the board edges; the result saturates at 7.
module m_run_counter
  import m_board_keeper_pkg::*;
#(
  parameter int WIN_LEN = 4
) (
  input  logic [`FIELD_SIZE-1:0] field,
  input  logic [2:0]             row,
  input  logic [2:0]             col,
  input  logic signed [1:0]      dr,
  input  logic signed [1:0]      dc,
  output logic [2:0]             run
);

  int   total;
  int   r;
  int   c;
  logic go;
  logic hit;

  always_comb begin
    total = 1;
    r     = 0;
    c     = 0;
    hit   = 1'b0;
    go    = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      r   = int'(row) + int'(dr) * k;
      c   = int'(col) + int'(dc) * k;
      hit = 1'b0;
      // Row/col bounds are checked separately so col 6 never continues into the next row.
      if (r >= 0 && r < N_ROWS && c >= 0 && c < N_COLS)
        hit = field[6'(r * N_COLS + c)];
      if (go && hit) total = total + 1;
      else           go    = 1'b0;
    end
    go = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      r   = int'(row) - int'(dr) * k;
      c   = int'(col) - int'(dc) * k;
      hit = 1'b0;
      if (r >= 0 && r < N_ROWS && c >= 0 && c < N_COLS)
        hit = field[6'(r * N_COLS + c)];
      if (go && hit) total = total + 1;
      else           go    = 1'b0;
    end
    run = (total > 7) ? 3'd7 : 3'(total);
  end

endmodule

// File: rtl/m_board_keeper.sv
// Authoritative Connect-Four board: accepts moves, drops pieces, classifies each move.
// Board outputs only change at the PLACE edge or on clear/reset, so readers see a stable board during CHK.
module m_board_keeper
  import m_board_keeper_pkg::*;
#(
  parameter int WIN_LEN = 4
) (
  input  logic                                 w_clk,
  input  logic                                 w_rst,
  input  logic                                 i_clear,
  input  logic                                 i_move_valid,
  input  logic [`COL_SIZE-1:0]                 i_move_col,
  input  logic                                 i_move_is_me,
  output logic                                 o_ready,
  output logic                                 o_done,
  output logic [1:0]                           o_result,
  output logic                                 o_game_over,
  output logic [`FIELD_SIZE-1:0]               o_me_field,
  output logic [`FIELD_SIZE-1:0]               o_op_field,
  output logic [`PILED_COUNT_ARRAY_SIZE-1:0]   o_piled_array
);

  state_t              state_q, state_n;
  logic [1:0]          d_q, d_n;
  logic [2:0]          col_q, col_n;
  logic [2:0]          row_q, row_n;
  logic                side_q, side_n;
  logic                win_q, win_n;
  logic [FIELD_W-1:0]  me_q, me_n, op_q, op_n;
  pile_t               pile_q, pile_n;
  logic                done_q, done_n;
  logic [1:0]          res_q, res_n;
  logic                over_q, over_n;

  logic [2:0]          cur_pile;
  logic                full;
  logic [2:0]          run;
  dir_t                dir;
  logic [5:0]          place_idx;

  assign dir = dir_of(d_q);

  m_run_counter #(.WIN_LEN(WIN_LEN)) u_run (
    .field (side_q ? me_q : op_q),
    .row   (row_q),
    .col   (col_q),
    .dr    (dir.dr),
    .dc    (dir.dc),
    .run   (run)
  );

  // Out-of-range columns read as a full pile so they fall into the illegal path.
  assign cur_pile  = (col_q < 3'(N_COLS)) ? pile_q[col_q] : 3'(N_ROWS);
  assign place_idx = cell_idx(cur_pile, col_q);

  always_comb begin
    full = 1'b1;
    for (int c = 0; c < N_COLS; c++)
      if (pile_q[c] != 3'(N_ROWS)) full = 1'b0;
  end

  always_comb begin
    state_n = state_q;
    d_n     = d_q;
    col_n   = col_q;
    row_n   = row_q;
    side_n  = side_q;
    win_n   = win_q;
    me_n    = me_q;
    op_n    = op_q;
    pile_n  = pile_q;
    done_n  = 1'b0;
    res_n   = res_q;
    over_n  = over_q;

    if (i_clear) begin
      state_n = S_IDLE;
      me_n    = '0;
      op_n    = '0;
      pile_n  = '0;
      over_n  = 1'b0;
      win_n   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_move_valid) begin
            col_n   = i_move_col;
            side_n  = i_move_is_me;
            win_n   = 1'b0;
            state_n = S_PLACE;
          end
        end
        S_PLACE: begin
          if (col_q >= 3'(N_COLS) || cur_pile == 3'(N_ROWS) || over_q) begin
            done_n  = 1'b1;
            res_n   = `RES_ILLEGAL;
            state_n = S_IDLE;
          end else begin
            if (side_q) me_n[place_idx] = 1'b1;
            else        op_n[place_idx] = 1'b1;
            pile_n[col_q] = cur_pile + 3'd1;
            row_n         = cur_pile;
            d_n           = 2'd0;
            state_n       = S_CHK;
          end
        end
        S_CHK: begin
          if (int'(run) >= WIN_LEN) win_n = 1'b1;
          if (d_q == 2'd3) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
            if (win_n) begin
              res_n  = `RES_WIN;
              over_n = 1'b1;
            end else if (full) begin
              res_n  = `RES_DRAW;
              over_n = 1'b1;
            end else begin
              res_n  = `RES_OK;
            end
          end else begin
            d_n = d_q + 2'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      side_q  <= 1'b0;
      win_q   <= 1'b0;
      me_q    <= '0;
      op_q    <= '0;
      pile_q  <= '0;
      done_q  <= 1'b0;
      res_q   <= `RES_OK;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      d_q     <= d_n;
      col_q   <= col_n;
      row_q   <= row_n;
      side_q  <= side_n;
      win_q   <= win_n;
      me_q    <= me_n;
      op_q    <= op_n;
      pile_q  <= pile_n;
      done_q  <= done_n;
      res_q   <= res_n;
      over_q  <= over_n;
    end
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_done        = done_q;
  assign o_result      = res_q;
  assign o_game_over   = over_q;
  assign o_me_field    = me_q;
  assign o_op_field    = op_q;
  assign o_piled_array = pile_q;

endmodule

// File: tb/tb_m_board_keeper.sv
// Directed bench for m_board_keeper: win, illegal, full column, row wrap, draw, reset/clear mid-check.
module tb_m_board_keeper;

  localparam logic [1:0] OK  = 2'd0;
  localparam logic [1:0] WIN = 2'd1;
  localparam logic [1:0] DRW = 2'd2;
  localparam logic [1:0] ILL = 2'd3;

  logic        w_clk;
  logic        w_rst;
  logic        i_clear;
  logic        i_move_valid;
  logic [2:0]  i_move_col;
  logic        i_move_is_me;
  logic        o_ready;
  logic        o_done;
  logic [1:0]  o_result;
  logic        o_game_over;
  logic [41:0] o_me_field;
  logic [41:0] o_op_field;
  logic [20:0] o_piled_array;

  int n_pass = 0;
  int n_tot  = 0;

  m_board_keeper #(.WIN_LEN(4)) dut (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .i_clear       (i_clear),
    .i_move_valid  (i_move_valid),
    .i_move_col    (i_move_col),
    .i_move_is_me  (i_move_is_me),
    .o_ready       (o_ready),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_game_over   (o_game_over),
    .o_me_field    (o_me_field),
    .o_op_field    (o_op_field),
    .o_piled_array (o_piled_array)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic accept(input logic [2:0] col, input logic me);
    chk("ready_before_accept", {63'd0, o_ready}, 64'd1);
    i_move_valid = 1'b1;
    i_move_col   = col;
    i_move_is_me = me;
    @(posedge w_clk); #1;
    i_move_valid = 1'b0;
  endtask

  task automatic move(input string tag, input logic [2:0] col, input logic me,
                      input int exp_lat, input logic [1:0] exp_res);
    int lat;
    accept(col, me);
    lat = 0;
    do begin
      @(posedge w_clk); #1;
      lat++;
    end while (!o_done && lat < 10);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, {62'd0, o_result}, {62'd0, exp_res});
  endtask

  task automatic clear_board();
    i_clear = 1'b1;
    @(posedge w_clk); #1;
    i_clear = 1'b0;
  endtask

  function automatic logic draw_owner_me(input int r, input int c);
    return (((c + 2 * (r % 2)) % 4) / 2) == 0;
  endfunction

  initial begin
    logic [41:0] me_exp;
    logic        saw_done;

    w_rst = 1'b1;
    i_clear = 1'b0;
    i_move_valid = 1'b0;
    i_move_col = 3'd0;
    i_move_is_me = 1'b0;
    @(posedge w_clk); #1;
    chk("rst_ready",  {63'd0, o_ready}, 64'd1);
    chk("rst_done",   {63'd0, o_done}, 64'd0);
    chk("rst_result", {62'd0, o_result}, 64'd0);
    chk("rst_over",   {63'd0, o_game_over}, 64'd0);
    chk("rst_me",     {22'd0, o_me_field}, 64'd0);
    chk("rst_op",     {22'd0, o_op_field}, 64'd0);
    chk("rst_piles",  {43'd0, o_piled_array}, 64'd0);
    @(posedge w_clk); #1;
    w_rst = 1'b0;

    // Column 7 from an empty board.
    move("col7", 3'd7, 1'b1, 1, ILL);
    chk("col7_me",    {22'd0, o_me_field}, 64'd0);
    chk("col7_op",    {22'd0, o_op_field}, 64'd0);
    chk("col7_piles", {43'd0, o_piled_array}, 64'd0);

    // Vertical win by op in column 1.
    move("pre0", 3'd0, 1'b1, 5, OK);
    move("pre1", 3'd1, 1'b0, 5, OK);
    move("pre2", 3'd0, 1'b1, 5, OK);
    move("pre3", 3'd1, 1'b0, 5, OK);
    move("pre4", 3'd1, 1'b0, 5, OK);
    chk("pre_piles", {43'd0, o_piled_array}, 64'h1A);
    move("vwin", 3'd1, 1'b0, 5, WIN);
    chk("vwin_op",    {22'd0, o_op_field}, 64'h408102);
    chk("vwin_me",    {22'd0, o_me_field}, 64'h81);
    chk("vwin_piles", {43'd0, o_piled_array}, 64'h22);
    chk("vwin_over",  {63'd0, o_game_over}, 64'd1);
    move("after_over", 3'd2, 1'b1, 1, ILL);
    chk("after_over_op",    {22'd0, o_op_field}, 64'h408102);
    chk("after_over_me",    {22'd0, o_me_field}, 64'h81);
    chk("after_over_piles", {43'd0, o_piled_array}, 64'h22);

    clear_board();
    chk("clr_over",  {63'd0, o_game_over}, 64'd0);
    chk("clr_me",    {22'd0, o_me_field}, 64'd0);
    chk("clr_piles", {43'd0, o_piled_array}, 64'd0);
    chk("clr_ready", {63'd0, o_ready}, 64'd1);

    // Fill column 3, then overflow it.
    for (int i = 0; i < 6; i++) move("col3_fill", 3'd3, i[0], 5, OK);
    chk("col3_piles", {43'd0, o_piled_array}, 64'hC00);
    move("col3_full", 3'd3, 1'b1, 1, ILL);
    chk("col3_full_piles", {43'd0, o_piled_array}, 64'hC00);
    clear_board();

    // Row 0 cols 4..6 plus row 1 col 0 are bits 4..7 but not a line.
    move("wrap4", 3'd4, 1'b1, 5, OK);
    move("wrap5", 3'd5, 1'b1, 5, OK);
    move("wrap6", 3'd6, 1'b1, 5, OK);
    move("wrap_op0", 3'd0, 1'b0, 5, OK);
    move("wrap_me0", 3'd0, 1'b1, 5, OK);
    chk("wrap_me",    {22'd0, o_me_field}, 64'hF0);
    chk("wrap_op",    {22'd0, o_op_field}, 64'h1);
    chk("wrap_piles", {43'd0, o_piled_array}, 64'h49002);
    chk("wrap_over",  {63'd0, o_game_over}, 64'd0);
    clear_board();

    // Full board with no four-in-a-row anywhere.
    me_exp = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        if (draw_owner_me(r, c)) me_exp[7*r+c] = 1'b1;
        move("draw_fill", 3'(c), draw_owner_me(r, c), 5, (r == 5 && c == 6) ? DRW : OK);
      end
    chk("draw_over",  {63'd0, o_game_over}, 64'd1);
    chk("draw_me",    {22'd0, o_me_field}, {22'd0, me_exp});
    chk("draw_op",    {22'd0, o_op_field}, {22'd0, ~me_exp});
    chk("draw_piles", {43'd0, o_piled_array}, {43'd0, 21'o6666666});
    clear_board();

    // Async reset while checking direction 2.
    accept(3'd2, 1'b1);
    repeat (3) @(posedge w_clk);
    #1 w_rst = 1'b1;
    #1;
    chk("rstchk_done",  {63'd0, o_done}, 64'd0);
    chk("rstchk_ready", {63'd0, o_ready}, 64'd1);
    chk("rstchk_me",    {22'd0, o_me_field}, 64'd0);
    chk("rstchk_piles", {43'd0, o_piled_array}, 64'd0);
    chk("rstchk_res",   {62'd0, o_result}, 64'd0);
    @(posedge w_clk); #1;
    w_rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge w_clk); #1;
      if (o_done) saw_done = 1'b1;
    end
    chk("rstchk_no_done", {63'd0, saw_done}, 64'd0);

    // Clear while checking.
    move("pre_clr", 3'd5, 1'b0, 5, OK);
    accept(3'd5, 1'b1);
    repeat (2) @(posedge w_clk);
    #1 i_clear = 1'b1;
    @(posedge w_clk); #1;
    i_clear = 1'b0;
    chk("clrchk_ready", {63'd0, o_ready}, 64'd1);
    chk("clrchk_done",  {63'd0, o_done}, 64'd0);
    chk("clrchk_me",    {22'd0, o_me_field}, 64'd0);
    chk("clrchk_op",    {22'd0, o_op_field}, 64'd0);
    chk("clrchk_piles", {43'd0, o_piled_array}, 64'd0);
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge w_clk); #1;
      if (o_done) saw_done = 1'b1;
    end
    chk("clrchk_no_done", {63'd0, saw_done}, 64'd0);
    move("post_clr", 3'd5, 1'b1, 5, OK);
    chk("post_clr_me", {22'd0, o_me_field}, 64'h20);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
